display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit BCD display scanner with shadow-buffered loads,
// guard gaps between digit slots, digit suppression and leading-zero blanking.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        lzb_en,
    output logic [3:0]  s_out,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        ON    = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   active, shadow;
    logic          pend;
    logic [1:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    s_last;
    logic          commit, accept;
    logic [3:0]    digit, s_cur;
    logic          upper_zero, digit_bad, suppress;

    assign load_ready = ~pend;
    assign accept     = load_valid & ~pend;

    // upper_zero: this digit and every digit above it are zero (never for digit 0)
    always_comb begin
        digit      = 4'd0;
        upper_zero = 1'b0;
        case (idx)
            2'd0: begin
                digit      = active[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                digit      = active[7:4];
                upper_zero = (active[15:4] == 12'd0);
            end
            2'd2: begin
                digit      = active[11:8];
                upper_zero = (active[15:8] == 8'd0);
            end
            default: begin
                digit      = active[15:12];
                upper_zero = (active[15:12] == 4'd0);
            end
        endcase
    end

    assign digit_bad = (digit > 4'd9);
    assign suppress  = digit_bad | (lzb_en & upper_zero);
    assign s_cur     = digit_bad ? 4'd0 : digit;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        commit     = 1'b0;
        an         = 4'b1111;
        s_out      = 4'd0;
        frame_tick = 1'b0;
        case (state)
            BLANK: begin
                if (pend) begin
                    commit    = 1'b1;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = '0;
                    state_nxt = ON;
                end
            end
            ON: begin
                s_out = s_cur;
                if (!suppress) begin
                    an = ~(4'b0001 << idx);
                end
                if (cnt == ON_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = GUARD;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GUARD: begin
                s_out = s_last;
                if (cnt == GUARD_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                    state_nxt = ON;
                    // Frame boundary: the only place a mid-scan update may land.
                    if (idx == 2'd3) begin
                        frame_tick = 1'b1;
                        commit     = pend;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BLANK;
            idx    <= 2'd0;
            cnt    <= '0;
            pend   <= 1'b0;
            active <= 16'd0;
            shadow <= 16'd0;
            s_last <= 4'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            if (state == ON) begin
                s_last <= s_cur;
            end
            if (commit) begin
                active <= shadow;
                pend   <= 1'b0;
            end else if (accept) begin
                shadow <= load_data;
                pend   <= 1'b1;
            end
        end
    end

endmodule
